// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage and its neighbours.
// Control-word bit positions, widths and the MEM FSM encoding.
package mem_access_stage_pkg;

  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMTOREG = 1;
  localparam int CTL_BRANCH   = 2;
  localparam int CTL_MEMREAD  = 3;
  localparam int CTL_MEMWRITE = 4;

  localparam int CTL_WIDTH    = 9;
  localparam int WB_CTL_WIDTH = 2;
  localparam int XLEN         = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Ports: clk, we, clr_sel/clr_addr (sweep), idx/store_data (pipeline), rdata.
module data_memory
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 clr_sel,
  input  logic [ADDR_BITS-1:0] clr_addr,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [XLEN-1:0]      store_data,
  output logic [XLEN-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [XLEN-1:0]      mem_q [DEPTH];
  logic [ADDR_BITS-1:0] waddr;
  logic [XLEN-1:0]      wdata;

  // The clear sweep owns the write port while it runs.
  always_comb begin
    waddr = clr_sel ? clr_addr : idx;
    wdata = clr_sel ? '0 : store_data;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data memory access, branch resolve, MEM/WB register.
// Clears the memory after reset and stalls upstream until the sweep ends.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int REG_BITS  = 6
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [XLEN-1:0]         I_MEM_PC,
  input  logic [XLEN-1:0]         I_MEM_ALU_result,
  input  logic [XLEN-1:0]         I_MEM_ReadData,
  input  logic [REG_BITS-1:0]     I_MEM_regDst,
  input  logic [CTL_WIDTH-1:0]    I_MEM_ControlReg,
  input  logic                    I_MEM_zeroFlag,
  output logic                    PCSrc_out,
  output logic [XLEN-1:0]         BranchTarget_out,
  output logic [XLEN-1:0]         MemData_out,
  output logic [XLEN-1:0]         ALU_result_out,
  output logic [REG_BITS-1:0]     regDst_out,
  output logic [WB_CTL_WIDTH-1:0] ControlReg_out,
  output logic                    Stall_out
);

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    clr_ptr_q, clr_ptr_d;
  logic [XLEN-1:0]         mem_data_q, mem_data_d;
  logic [XLEN-1:0]         alu_q, alu_d;
  logic [REG_BITS-1:0]     rd_q, rd_d;
  logic [WB_CTL_WIDTH-1:0] ctl_q, ctl_d;

  logic [ADDR_BITS-1:0] idx;
  logic [XLEN-1:0]      rdata;
  logic                 we;
  logic                 clr_sel;
  logic                 busy;
  logic                 unused_ctl;

  assign idx        = I_MEM_ALU_result[ADDR_BITS+1:2];
  assign busy       = (state_q == ST_INIT);
  assign unused_ctl = ^I_MEM_ControlReg[CTL_WIDTH-1:5];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    mem_data_d = mem_data_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    ctl_d      = ctl_q;
    we         = 1'b0;
    clr_sel    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        we        = ~RESET;
        clr_sel   = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        we = ~RESET & I_MEM_ControlReg[CTL_MEMWRITE];
        // Read is combinational, so a same-edge store yields the old word.
        mem_data_d = I_MEM_ControlReg[CTL_MEMREAD] ? rdata : '0;
        alu_d      = I_MEM_ALU_result;
        rd_d       = I_MEM_regDst;
        ctl_d      = {I_MEM_ControlReg[CTL_MEMTOREG],
                      I_MEM_ControlReg[CTL_REGWRITE]};
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_INIT;
      clr_ptr_q  <= '0;
      mem_data_q <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      mem_data_q <= mem_data_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      ctl_q      <= ctl_d;
    end
  end

  data_memory #(
    .ADDR_BITS(ADDR_BITS)
  ) u_dmem (
    .clk       (CLK),
    .we        (we),
    .clr_sel   (clr_sel),
    .clr_addr  (clr_ptr_q),
    .idx       (idx),
    .store_data(I_MEM_ReadData),
    .rdata     (rdata)
  );

  assign PCSrc_out = I_MEM_ControlReg[CTL_BRANCH]
                   & I_MEM_zeroFlag & ~busy;

  assign BranchTarget_out = I_MEM_PC;
  assign MemData_out      = mem_data_q;
  assign ALU_result_out   = alu_q;
  assign regDst_out       = rd_q;
  assign ControlReg_out   = ctl_q;
  assign Stall_out        = busy;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage.
// Vector table, hand sequences, and a random run against a memory model.
module tb_mem_access_stage;

  localparam int RB    = 6;
  localparam int DEPTH = 256;

  localparam logic [4:0] C_RW  = 5'b00001;
  localparam logic [4:0] C_MTR = 5'b00010;
  localparam logic [4:0] C_BR  = 5'b00100;
  localparam logic [4:0] C_RD  = 5'b01000;
  localparam logic [4:0] C_WR  = 5'b10000;
  localparam logic [4:0] C_LD  = C_RD | C_MTR | C_RW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   I_MEM_PC;
  logic [31:0]   I_MEM_ALU_result;
  logic [31:0]   I_MEM_ReadData;
  logic [RB-1:0] I_MEM_regDst;
  logic [8:0]    I_MEM_ControlReg;
  logic          I_MEM_zeroFlag;
  logic          PCSrc_out;
  logic [31:0]   BranchTarget_out;
  logic [31:0]   MemData_out;
  logic [31:0]   ALU_result_out;
  logic [RB-1:0] regDst_out;
  logic [1:0]    ControlReg_out;
  logic          Stall_out;

  mem_access_stage #(.ADDR_BITS(8), .REG_BITS(RB)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .I_MEM_PC        (I_MEM_PC),
    .I_MEM_ALU_result(I_MEM_ALU_result),
    .I_MEM_ReadData  (I_MEM_ReadData),
    .I_MEM_regDst    (I_MEM_regDst),
    .I_MEM_ControlReg(I_MEM_ControlReg),
    .I_MEM_zeroFlag  (I_MEM_zeroFlag),
    .PCSrc_out       (PCSrc_out),
    .BranchTarget_out(BranchTarget_out),
    .MemData_out     (MemData_out),
    .ALU_result_out  (ALU_result_out),
    .regDst_out      (regDst_out),
    .ControlReg_out  (ControlReg_out),
    .Stall_out       (Stall_out)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic [4:0]    ctl;
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic [RB-1:0] rd;
    logic [31:0]   exp_mem;
    logic [1:0]    exp_ctl;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [RB-1:0] rd);
    I_MEM_ControlReg = {4'b0, ctl};
    I_MEM_ALU_result = addr;
    I_MEM_ReadData   = wd;
    I_MEM_regDst     = rd;
  endtask

  // Runs the sweep while hammering stores/branches that must be ignored.
  task automatic wait_sweep(input string tag);
    int cyc;
    bit bad;
    cyc = 0;
    bad = 0;
    drive(5'b11111, 32'h8, 32'h77, 6'd9);
    I_MEM_zeroFlag = 1'b1;
    I_MEM_PC       = 32'h100;
    #1;
    while (Stall_out === 1'b1 && cyc < 1000) begin
      if (PCSrc_out !== 1'b0 || MemData_out !== 0 ||
          ALU_result_out !== 0 || regDst_out !== 0 ||
          ControlReg_out !== 0)
        bad = 1;
      step;
      cyc++;
    end
    chk({tag, "_stall_cycles"}, cyc, 256);
    chk({tag, "_init_quiet"}, {31'b0, bad}, 0);
    drive(5'b0, 0, 0, 0);
    I_MEM_zeroFlag = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    vecs[0] = '{C_WR, 32'h010, 32'hDEADBEEF, 6'd1, 32'h0, 2'b00};
    vecs[1] = '{C_LD, 32'h010, 32'h0, 6'd5, 32'hDEADBEEF, 2'b11};
    vecs[2] = '{C_WR, 32'h413, 32'h12345678, 6'd2, 32'h0, 2'b00};
    vecs[3] = '{C_LD, 32'h010, 32'h0, 6'd7, 32'h12345678, 2'b11};
    vecs[4] = '{C_WR, 32'h020, 32'h0000000A, 6'd0, 32'h0, 2'b00};
    vecs[5] = '{C_RD | C_WR, 32'h020, 32'h0000000B, 6'd3,
                32'h0000000A, 2'b00};
    vecs[6] = '{C_LD, 32'h020, 32'h0, 6'd4, 32'h0000000B, 2'b11};
    vecs[7] = '{C_LD, 32'h3FC, 32'h0, 6'd63, 32'h0, 2'b11};
    vecs[8] = '{C_RW, 32'h010, 32'h0, 6'd8, 32'h0, 2'b01};
    vecs[9] = '{C_RD | C_MTR, 32'hFFFF_F022, 32'h0, 6'd10,
                32'h0000000B, 2'b10};

    RESET = 1'b1;
    I_MEM_PC = 0;
    I_MEM_zeroFlag = 1'b0;
    drive(5'b0, 0, 0, 0);
    step;
    step;
    chk("rst_stall", {31'b0, Stall_out}, 1);
    chk("rst_mem", MemData_out, 0);
    chk("rst_alu", ALU_result_out, 0);
    chk("rst_rd", {26'b0, regDst_out}, 0);
    chk("rst_ctl", {30'b0, ControlReg_out}, 0);
    drive(C_BR, 0, 0, 0);
    I_MEM_zeroFlag = 1'b1;
    #1;
    chk("rst_pcsrc", {31'b0, PCSrc_out}, 0);
    RESET = 1'b0;
    wait_sweep("sweep1");

    I_MEM_PC = 32'h40;
    I_MEM_zeroFlag = 1'b1;
    drive(C_BR, 0, 0, 0);
    #1;
    chk("br_taken", {31'b0, PCSrc_out}, 1);
    chk("br_target", BranchTarget_out, 32'h40);
    I_MEM_zeroFlag = 1'b0;
    #1;
    chk("br_not_taken", {31'b0, PCSrc_out}, 0);
    drive(5'b0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].addr, vecs[i].wd, vecs[i].rd);
      step;
      if (vecs[i].ctl[4]) model[vecs[i].addr[9:2]] = vecs[i].wd;
      chk($sformatf("vec%0d_mem", i), MemData_out, vecs[i].exp_mem);
      chk($sformatf("vec%0d_alu", i), ALU_result_out, vecs[i].addr);
      chk($sformatf("vec%0d_rd", i), {26'b0, regDst_out},
          {26'b0, vecs[i].rd});
      chk($sformatf("vec%0d_ctl", i), {30'b0, ControlReg_out},
          {30'b0, vecs[i].exp_ctl});
    end

    for (int n = 0; n < 400; n++) begin
      logic [4:0]    ctl;
      logic [31:0]   addr, wd, exp_mem;
      logic [RB-1:0] rd;
      logic          z;
      ctl  = 5'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[31:6] = '0;
      wd   = $urandom;
      rd   = RB'($urandom);
      z    = 1'($urandom);
      I_MEM_PC = $urandom;
      I_MEM_zeroFlag = z;
      drive(ctl, addr, wd, rd);
      #1;
      if (PCSrc_out !== (ctl[2] & z) || BranchTarget_out !== I_MEM_PC)
        chk($sformatf("rnd%0d_branch", n), {31'b0, PCSrc_out},
            {31'b0, ctl[2] & z});
      exp_mem = ctl[3] ? model[addr[9:2]] : 32'h0;
      if (ctl[4]) model[addr[9:2]] = wd;
      step;
      chk($sformatf("rnd%0d_mem", n), MemData_out, exp_mem);
      if (ALU_result_out !== addr || regDst_out !== rd ||
          ControlReg_out !== {ctl[1], ctl[0]})
        chk($sformatf("rnd%0d_fwd", n), ALU_result_out ^ 32'(regDst_out)
            ^ 32'(ControlReg_out), addr ^ 32'(rd) ^ 32'({ctl[1], ctl[0]}));
    end
    I_MEM_zeroFlag = 1'b0;

    drive(C_WR, 32'h8, 32'h55, 6'd0);
    step;
    drive(C_LD, 32'h8, 32'h0, 6'd1);
    step;
    chk("pre_rst_load", MemData_out, 32'h55);
    RESET = 1'b1;
    step;
    RESET = 1'b0;
    drive(C_WR, 32'h30, 32'hFFFF, 6'd0);
    for (int i = 0; i < 100; i++) step;
    chk("mid_sweep_stall", {31'b0, Stall_out}, 1);
    RESET = 1'b1;
    step;
    step;
    RESET = 1'b0;
    wait_sweep("sweep2");

    drive(C_LD, 32'h8, 32'h0, 6'd1);
    step;
    chk("post_rst_load8", MemData_out, 32'h0);
    drive(C_LD, 32'h30, 32'h0, 6'd1);
    step;
    chk("post_rst_load30", MemData_out, 32'h0);
    drive(C_LD, 32'h10, 32'h0, 6'd1);
    step;
    chk("post_rst_load10", MemData_out, 32'h0);
    drive(C_LD, 32'h20, 32'h0, 6'd1);
    step;
    chk("post_rst_load20", MemData_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Fourth pipeline stage (MEM), directly downstream of the EX stage and fed by the EX/MEM register outputs.
- Holds the word-addressed data memory and resolves the branch decision (PCSrc plus target) for the fetch stage.
- Registers its results into the MEM/WB pipeline register for the write-back stage.
- After reset, runs a clear sweep over the memory and raises a stall until the sweep completes.

Parameters:
- ADDR_BITS, 8, log2 of data memory depth in 32-bit words (256 words).
- REG_BITS, 6, width of the destination register index (matches the EX regDst path).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_MEM_PC  in  32  branch target computed in EX.
- I_MEM_ALU_result  in  32  ALU result; used as the byte address for loads and stores.
- I_MEM_ReadData  in  32  store data (rt value).
- I_MEM_regDst  in  REG_BITS  destination register index.
- I_MEM_ControlReg  in  9  control bits: [0] RegWrite, [1] MemToReg, [2] Branch, [3] MemRead, [4] MemWrite; [8:5] ignored.
- I_MEM_zeroFlag  in  1  ALU zero flag.
- PCSrc_out  out  1  branch taken, combinational: Branch & zeroFlag & ~init_busy.
- BranchTarget_out  out  32  equals I_MEM_PC, combinational.
- MemData_out  out  32  MEM/WB: data loaded from memory.
- ALU_result_out  out  32  MEM/WB: ALU result passed through.
- regDst_out  out  REG_BITS  MEM/WB: destination register.
- ControlReg_out  out  2  MEM/WB: {MemToReg, RegWrite}.
- Stall_out  out  1  high while the clear sweep is active; the hazard unit freezes upstream stages.

Behaviour:
- Word index = I_MEM_ALU_result[ADDR_BITS+1:2].
  - Address bits [1:0] are ignored; no alignment trap.
  - Upper bits above ADDR_BITS+1 are ignored, so addresses wrap modulo depth.
- Store: when MemWrite=1 and not busy, mem[idx] <= I_MEM_ReadData at the clock edge. Word writes only.
- Load: asynchronous read of mem[idx]; the value is captured into MemData_out at the same edge.
  - If MemRead and MemWrite are both 1, the write occurs and MemData_out captures the OLD word (read-before-write).
  - If MemRead=0, MemData_out captures 32'h0.
- MEM/WB register latency is 1 cycle. All pipeline fields update every cycle unless in the INIT state.
- FSM states:
  - INIT: entered on RESET=1. Clear counter clr_ptr <= 0. Each cycle mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1. After writing the last index (2^ADDR_BITS - 1), go to RUN. Sweep lasts exactly 2^ADDR_BITS cycles after reset deasserts.
  - RUN: normal operation; the state is left only by RESET.
- While in INIT:
  - Stall_out=1.
  - Pipeline stores are ignored (no memory write).
  - PCSrc_out=0.
  - MEM/WB outputs held at their reset values.
- Reset values, applied while RESET=1 and held through INIT:
  - MemData_out=0, ALU_result_out=0, regDst_out=0, ControlReg_out=2'b00.
  - Stall_out=1, clr_ptr=0.
- RESET asserted mid-sweep or mid-RUN: the sweep restarts from index 0 and any partially cleared or written contents are re-cleared.
- Branch decision is purely combinational from inputs. It is not registered here; the EX/MEM register already holds it stable for one cycle.
- Back-to-back store then load to the same address on consecutive cycles: the load sees the stored value (the write committed at the prior edge).

Decomposition:
- Shared package/header:
  - Control bit index constants CTL_REGWRITE=0, CTL_MEMTOREG=1, CTL_BRANCH=2, CTL_MEMREAD=3, CTL_MEMWRITE=4.
  - FSM state encodings ST_INIT, ST_RUN.
  - Constants reused by the EX and WB stages.
- One natural sub-module, data_memory: the synchronous-write/asynchronous-read word array with a write-enable, a write address mux (clr_ptr vs pipeline index) and a write data mux (0 vs store data), all controlled by the stage.
- The MEM/WB register and FSM stay in mem_access_stage.

Test Plan:
- Reset then sweep: pulse RESET 2 cycles -> Stall_out=1 for exactly 256 cycles after deassert, then 0; a load from 0x3FC afterwards returns 0.
- Store/load: store 0xDEADBEEF to 0x10, next cycle load 0x10 -> MemData_out=0xDEADBEEF one cycle after the load; ControlReg_out reflects the load's {MemToReg, RegWrite}={1,1}.
- Wrap and alignment: store 0x12345678 to 0x413 -> load from 0x010 returns 0x12345678.
- Read-before-write: mem[0x20]=0xA; MemRead=MemWrite=1 at 0x20 with data 0xB -> MemData_out=0xA; next load returns 0xB.
- Branch: Branch=1, zeroFlag=1, I_MEM_PC=0x40 -> PCSrc_out=1, BranchTarget_out=0x40 in the same cycle; zeroFlag=0 -> PCSrc_out=0; during INIT -> PCSrc_out=0.
- Reset mid-operation: store 0x55 to 0x8, assert RESET mid-run, wait for sweep completion -> load 0x8 returns 0, and no store issued during INIT modifies memory.
